// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Sits in front of the byte-serial memory controller and serialises two
//   clients onto its single new_task interface:
//     - instruction fetch: line fills of LINE_WORDS consecutive word reads
//     - load/store buffer: single byte / half-word / word accesses
//   One task is in flight at a time. Completion is taken from the
//   controller's busy flag, and read data is returned to the requester.
//   rob_clear aborts reads (no response is produced) but never disturbs
//   a store, matching the controller's own flush behaviour.
//
// Parameters:
//   LINE_WORDS  words per instruction line fill (power of 2, 1..16)
//   ADDR_W      address width
//
// Ports:
//   clk_in, rst_n_in     clock, asynchronous active-low reset
//   rdy_in               global enable; when low every register holds
//   rob_clear            pipeline flush
//   if_req / if_addr     line-fill request (held until if_last) and base
//   if_valid/idx/data    one returned word per pulse, if_last on the final
//   lsb_req ... lsb_type access request (held until lsb_done)
//   lsb_done/lsb_rdata   completion pulse and load data
//   mem_*  (outputs)     task fields towards the controller
//   mem_data_out/ready   controller read data / data-ready
//   mem_is_working       controller busy
//
// Build option:
//   MEM_ARB_IO_STALL_EN  when defined, adds input io_buffer_full. A store
//                        to the I/O window (lsb_addr[17:16] == 2'b11) is
//                        held off while io_buffer_full is high; other
//                        traffic, including instruction fetch, still flows.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              rob_clear,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [3:0]        if_idx,
    output logic [31:0]       if_data,
    output logic              if_last,

    input  logic              lsb_req,
    input  logic              lsb_is_write,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    input  logic [2:0]        lsb_type,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,

    output logic              mem_new_task,
    output logic              mem_is_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    output logic [2:0]        mem_work_type,
    input  logic [31:0]       mem_data_out,
    input  logic              mem_ready,
`ifdef MEM_ARB_IO_STALL_EN
    input  logic              io_buffer_full,
`endif
    input  logic              mem_is_working
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(LINE_WORDS - 1);
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic       PRI_IF    = 1'b0;
    localparam logic       PRI_LSB   = 1'b1;

    // Word address inside a line: base + 4*idx, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [3:0]        idx);
        return base + ADDR_W'({idx, 2'b00});
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                rr_pri_q,    rr_pri_d;
    logic                owner_lsb_q, owner_lsb_d;   // 1: current task is the LSB's
    logic                contested_q, contested_d;   // both clients wanted the grant

    logic                new_task_q,  new_task_d;
    logic                is_write_q,  is_write_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [2:0]          type_q,      type_d;

    logic                if_valid_q,  if_valid_d;
    logic [3:0]          if_idx_q,    if_idx_d;
    logic [31:0]         if_data_q,   if_data_d;
    logic                if_last_q,   if_last_d;
    logic                lsb_done_q,  lsb_done_d;
    logic [31:0]         lsb_rdata_q, lsb_rdata_d;

    logic                io_blocked;
    logic                if_pend;
    logic                lsb_pend;
    logic                pick_lsb;
    logic [3:0]          cnt_inc;
    logic                txn_end;

    // The controller's data-ready strobe is not needed: the read word is
    // stable once mem_is_working drops, which is when it is captured.
    logic                unused_ok;
    assign unused_ok = &{1'b0, mem_ready};

`ifdef MEM_ARB_IO_STALL_EN
    assign io_blocked = lsb_is_write && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
`else
    assign io_blocked = 1'b0;
`endif

    // Nothing new is started in a flush cycle, reads or writes alike.
    assign if_pend  = if_req  && !rob_clear;
    assign lsb_pend = lsb_req && !rob_clear && !io_blocked;
    assign pick_lsb = lsb_pend && (!if_pend || (rr_pri_q == PRI_LSB));
    assign cnt_inc  = cnt_q + 4'd1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_pri_d    = rr_pri_q;
        owner_lsb_d = owner_lsb_q;
        contested_d = contested_q;
        new_task_d  = new_task_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        type_d      = type_q;
        if_valid_d  = 1'b0;
        if_idx_d    = if_idx_q;
        if_data_d   = if_data_q;
        if_last_d   = 1'b0;
        lsb_done_d  = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
        txn_end     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (if_pend || lsb_pend) begin
                    state_d     = S_ISSUE;
                    new_task_d  = 1'b1;
                    owner_lsb_d = pick_lsb;
                    contested_d = if_pend && lsb_pend;
                    if (pick_lsb) begin
                        is_write_d = lsb_is_write;
                        addr_d     = lsb_addr;
                        wdata_d    = lsb_wdata;
                        type_d     = lsb_type;
                    end else begin
                        is_write_d = 1'b0;
                        addr_d     = word_addr(if_addr, cnt_q);
                        wdata_d    = '0;
                        type_d     = TYPE_WORD;
                    end
                end
            end

            S_ISSUE: begin
                if (rob_clear && !is_write_q) begin
                    // Aborted read: the controller drops it too, so no reply.
                    state_d    = S_IDLE;
                    new_task_d = 1'b0;
                    cnt_d      = '0;
                    txn_end    = 1'b1;
                end else if (rob_clear) begin
                    // The controller ignores new_task while flushing; keep
                    // the store strobe up so it is taken on the next cycle.
                    state_d    = S_ISSUE;
                    new_task_d = 1'b1;
                end else begin
                    state_d    = S_WAIT;
                    new_task_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (rob_clear && !is_write_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    txn_end = 1'b1;
                end else if (!mem_is_working) begin
                    if (owner_lsb_q) begin
                        lsb_done_d = 1'b1;
                        if (!is_write_q) begin
                            lsb_rdata_d = mem_data_out;
                        end
                        state_d = S_IDLE;
                        txn_end = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = mem_data_out;
                        if_idx_d   = cnt_q;
                        if (cnt_q == LAST_IDX) begin
                            if_last_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = S_IDLE;
                            txn_end   = 1'b1;
                        end else begin
                            // Line fills run back-to-back without re-arbitration.
                            cnt_d      = cnt_inc;
                            state_d    = S_ISSUE;
                            new_task_d = 1'b1;
                            addr_d     = word_addr(if_addr, cnt_inc);
                        end
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                new_task_d = 1'b0;
                cnt_d      = '0;
            end
        endcase

        // Priority only rotates after a grant that was actually contested.
        if (txn_end && contested_q) begin
            rr_pri_d    = owner_lsb_q ? PRI_IF : PRI_LSB;
            contested_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers (all frozen while rdy_in is low)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rr_pri_q    <= PRI_IF;
            owner_lsb_q <= 1'b0;
            contested_q <= 1'b0;
            new_task_q  <= 1'b0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            type_q      <= '0;
            if_valid_q  <= 1'b0;
            if_idx_q    <= '0;
            if_data_q   <= '0;
            if_last_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_pri_q    <= rr_pri_d;
            owner_lsb_q <= owner_lsb_d;
            contested_q <= contested_d;
            new_task_q  <= new_task_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            type_q      <= type_d;
            if_valid_q  <= if_valid_d;
            if_idx_q    <= if_idx_d;
            if_data_q   <= if_data_d;
            if_last_q   <= if_last_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign mem_new_task  = new_task_q;
    assign mem_is_write  = is_write_q;
    assign mem_addr      = addr_q;
    assign mem_data_in   = wdata_q;
    assign mem_work_type = type_q;
    assign if_valid      = if_valid_q;
    assign if_idx        = if_idx_q;
    assign if_data       = if_data_q;
    assign if_last       = if_last_q;
    assign lsb_done      = lsb_done_q;
    assign lsb_rdata     = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small controller model answers tasks:
// it accepts new_task on a rdy, non-flush cycle and stays busy for
// (bytes-1) cycles; read data is a fixed function of the task address.
// With MEM_ARB_IO_STALL_EN defined, the I/O store stall is exercised too.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic              rob_clear;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [3:0]        if_idx;
    logic [31:0]       if_data;
    logic              if_last;
    logic              lsb_req;
    logic              lsb_is_write;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_wdata;
    logic [2:0]        lsb_type;
    logic              lsb_done;
    logic [31:0]       lsb_rdata;
    logic              mem_new_task;
    logic              mem_is_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_in;
    logic [2:0]        mem_work_type;
    logic [31:0]       mem_data_out;
    logic              mem_ready;
    logic              mem_is_working;
`ifdef MEM_ARB_IO_STALL_EN
    logic              io_buffer_full;
`endif

    mem_arbiter #(.LINE_WORDS(4), .ADDR_W(ADDR_W)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .rob_clear      (rob_clear),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_valid       (if_valid),
        .if_idx         (if_idx),
        .if_data        (if_data),
        .if_last        (if_last),
        .lsb_req        (lsb_req),
        .lsb_is_write   (lsb_is_write),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_type       (lsb_type),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .mem_new_task   (mem_new_task),
        .mem_is_write   (mem_is_write),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_work_type  (mem_work_type),
        .mem_data_out   (mem_data_out),
        .mem_ready      (mem_ready),
`ifdef MEM_ARB_IO_STALL_EN
        .io_buffer_full (io_buffer_full),
`endif
        .mem_is_working (mem_is_working)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Controller read data as a function of the task address.
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (32'hA500_0000 | {8'h00, a[23:0]});
    endfunction

    // ---------------- controller model ----------------
    int          busy;
    logic [31:0] lat_addr;
    logic        cur_wr;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy     <= 0;
            lat_addr <= '0;
            cur_wr   <= 1'b0;
        end else if (rdy_in) begin
            if (mem_new_task && !rob_clear) begin
                busy     <= (mem_work_type[1:0] == 2'b10) ? 3 :
                            (mem_work_type[1:0] == 2'b01) ? 1 : 0;
                lat_addr <= mem_addr;
                cur_wr   <= mem_is_write;
            end else if (rob_clear && !cur_wr) begin
                busy <= 0;
            end else if (busy != 0) begin
                busy <= busy - 1;
            end
        end
    end

    assign mem_is_working = (busy != 0);
    assign mem_data_out   = rd_model(lat_addr);
    assign mem_ready      = 1'b0;

    // ---------------- monitors ----------------
    typedef struct { logic [31:0] addr; logic wr; logic [2:0] ty; logic [31:0] d; } task_t;
    typedef struct { logic [3:0] idx; logic [31:0] data; logic last; int cyc; } ifv_t;

    task_t tq[$];
    ifv_t  ifv[$];
    int    dq[$];
    int    nt_hi = 0;

    always @(posedge clk_in) begin
        if (rst_n_in && rdy_in && mem_new_task && !rob_clear)
            tq.push_back('{addr: mem_addr, wr: mem_is_write, ty: mem_work_type, d: mem_data_in});
    end

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (if_valid) ifv.push_back('{idx: if_idx, data: if_data, last: if_last, cyc: cyc});
            if (lsb_done) dq.push_back(cyc);
            if (mem_new_task) nt_hi++;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic wait_done(input int t0, output int lat, output logic [31:0] data);
        lat  = -1;
        data = '0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (lsb_done) begin
                lat  = cyc - t0;
                data = lsb_rdata;
                break;
            end
        end
        lsb_req = 1'b0;
    endtask

    task automatic set_lsb(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] ty);
        lsb_req      = 1'b1;
        lsb_is_write = wr;
        lsb_addr     = a;
        lsb_wdata    = wd;
        lsb_type     = ty;
    endtask

    task automatic run_if(input logic [31:0] a, output int lat);
        int t0;
        if_req  = 1'b1;
        if_addr = a;
        t0      = cyc;
        lat     = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (if_last) begin
                lat = cyc - t0;
                break;
            end
        end
        if_req = 1'b0;
    endtask

    // Raise both requests together; drop each on its completion.
    task automatic both_round(input logic [31:0] ia, input logic [31:0] la,
                              input logic [31:0] wd, output int t_if, output int t_ls);
        int t0;
        if_req  = 1'b1;
        if_addr = ia;
        set_lsb(1'b1, la, wd, 3'b000);
        t0   = cyc;
        t_if = -1;
        t_ls = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (if_last && t_if < 0) begin
                t_if   = cyc - t0;
                if_req = 1'b0;
            end
            if (lsb_done && t_ls < 0) begin
                t_ls    = cyc - t0;
                lsb_req = 1'b0;
            end
            if (t_if >= 0 && t_ls >= 0) break;
        end
        if_req  = 1'b0;
        lsb_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat, t0, t_if, t_ls, base, vb, db;
        logic [31:0] d;

        rst_n_in     = 1'b0;
        rdy_in       = 1'b1;
        rob_clear    = 1'b0;
        if_req       = 1'b0;
        if_addr      = '0;
        lsb_req      = 1'b0;
        lsb_is_write = 1'b0;
        lsb_addr     = '0;
        lsb_wdata    = '0;
        lsb_type     = '0;
`ifdef MEM_ARB_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif
        repeat (3) step();

        // Reset state
        chk("rst_new_task",  {31'd0, mem_new_task}, 32'd0);
        chk("rst_mem_addr",  mem_addr,              32'd0);
        chk("rst_work_type", {29'd0, mem_work_type}, 32'd0);
        chk("rst_if_valid",  {31'd0, if_valid},     32'd0);
        chk("rst_if_idx",    {28'd0, if_idx},       32'd0);
        chk("rst_if_data",   if_data,               32'd0);
        chk("rst_lsb_done",  {31'd0, lsb_done},     32'd0);
        chk("rst_lsb_rdata", lsb_rdata,             32'd0);

        rst_n_in = 1'b1;
        step();

        // Both pending from reset: ifetch wins, store follows
        both_round(32'h200, 32'h10, 32'h55, t_if, t_ls);
        chk("rr1_if_last_lat", t_if, 32'd21);
        chk("rr1_store_lat",   t_ls, 32'd24);
        chk("rr1_store_data",  tq[tq.size()-1].d, 32'h55);
        chk("rr1_store_wr",    {31'd0, tq[tq.size()-1].wr}, 32'd1);

        // Both pending again: store wins this time
        both_round(32'h200, 32'h14, 32'h66, t_if, t_ls);
        chk("rr2_store_lat",   t_ls, 32'd3);
        chk("rr2_if_last_lat", t_if, 32'd24);

        // Single word load
        base = tq.size();
        db   = nt_hi;
        set_lsb(1'b0, 32'h100, 32'h0, 3'b010);
        t0 = cyc;
        wait_done(t0, lat, d);
        chk("ld_latency", lat, 32'd6);
        chk("ld_rdata",   d,   32'hDEADBEEF);
        step();
        chk("ld_done_one_cycle", {31'd0, lsb_done}, 32'd0);
        chk("ld_task_count", tq.size() - base, 32'd1);
        chk("ld_task_addr",  tq[base].addr, 32'h100);
        chk("ld_task_type",  {29'd0, tq[base].ty}, 32'd2);
        chk("ld_nt_cycles",  nt_hi - db, 32'd1);

        // Line fill at 0x40
        base = tq.size();
        vb   = ifv.size();
        run_if(32'h40, lat);
        chk("lf_latency", lat, 32'd21);
        chk("lf_valid_count", ifv.size() - vb, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("lf_addr", tq[base+k].addr, 32'h40 + 32'(4*k));
            chk("lf_idx",  {28'd0, ifv[vb+k].idx}, 32'(k));
            chk("lf_data", ifv[vb+k].data, rd_model(32'h40 + 32'(4*k)));
            chk("lf_last", {31'd0, ifv[vb+k].last}, (k == 3) ? 32'd1 : 32'd0);
        end

        // Flush during the WAIT of word 2 of a line fill
        step();
        base    = tq.size();
        vb      = ifv.size();
        if_req  = 1'b1;
        if_addr = 32'h80;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ifv.size() - vb >= 2) break;
        end
        step();
        rob_clear = 1'b1;
        if_req    = 1'b0;
        step();
        rob_clear = 1'b0;
        chk("rcf_newtask_low", {31'd0, mem_new_task}, 32'd0);
        repeat (10) step();
        chk("rcf_valid_count", ifv.size() - vb, 32'd2);
        chk("rcf_task_count",  tq.size() - base, 32'd3);
        base = tq.size();
        vb   = ifv.size();
        run_if(32'h80, lat);
        chk("rcf_restart_lat",  lat, 32'd21);
        chk("rcf_restart_addr", tq[base].addr, 32'h80);
        chk("rcf_restart_idx",  {28'd0, ifv[vb].idx}, 32'd0);

        // Flush in the ISSUE cycle of a byte store
        step();
        base = tq.size();
        db   = dq.size();
        set_lsb(1'b1, 32'h20, 32'h12, 3'b000);
        t0 = cyc;
        step();
        rob_clear = 1'b1;
        step();
        chk("rcs_nt_held", {31'd0, mem_new_task}, 32'd1);
        rob_clear = 1'b0;
        step();
        chk("rcs_nt_drop", {31'd0, mem_new_task}, 32'd0);
        wait_done(t0, lat, d);
        chk("rcs_latency", lat, 32'd4);
        repeat (3) step();
        chk("rcs_done_count", dq.size() - db, 32'd1);
        chk("rcs_task_count", tq.size() - base, 32'd1);
        chk("rcs_task_data",  tq[base].d, 32'h12);

        // rdy_in low for 3 cycles during ISSUE
        set_lsb(1'b0, 32'h104, 32'h0, 3'b010);
        t0 = cyc;
        step();
        chk("rdy_nt_issue", {31'd0, mem_new_task}, 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy_nt_held", {31'd0, mem_new_task}, 32'd1);
        end
        rdy_in = 1'b1;
        wait_done(t0, lat, d);
        chk("rdy_latency", lat, 32'd9);
        chk("rdy_rdata",   d,   32'hA5000104);

        // Load request ignored while rob_clear is held in IDLE
        step();
        base      = tq.size();
        rob_clear = 1'b1;
        set_lsb(1'b0, 32'h108, 32'h0, 3'b010);
        repeat (4) step();
        chk("rci_no_grant", tq.size() - base, 32'd0);
        chk("rci_nt_low",   {31'd0, mem_new_task}, 32'd0);
        rob_clear = 1'b0;
        t0 = cyc;
        wait_done(t0, lat, d);
        chk("rci_latency", lat, 32'd6);
        chk("rci_rdata",   d,   32'hA5000108);

`ifdef MEM_ARB_IO_STALL_EN
        // I/O store held off by io_buffer_full
        step();
        base           = tq.size();
        db             = dq.size();
        io_buffer_full = 1'b1;
        set_lsb(1'b1, 32'h30000, 32'h77, 3'b000);
        repeat (8) step();
        chk("io_no_grant", tq.size() - base, 32'd0);
        chk("io_no_done",  dq.size() - db,   32'd0);
        io_buffer_full = 1'b0;
        t0 = cyc;
        wait_done(t0, lat, d);
        chk("io_latency",   lat, 32'd3);
        chk("io_task_addr", tq[base].addr, 32'h30000);
`endif

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Upstream arbiter in front of the byte-serial memory controller (MemCtrl). It takes requests from two clients and issues one task at a time over the controller's new_task interface. The instruction-fetch client asks for line fills of LINE_WORDS word reads. The load/store buffer (LSB) client asks for single byte, half-word or word accesses. The arbiter watches controller status for completion and returns data to the requester, with rob_clear semantics that match the controller.

Parameters:
LINE_WORDS, 4, words per ifetch line fill (power of 2, 1..16)
ADDR_W, 32, address width

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low freezes all state
rob_clear  in  1  flush: abort reads, never writes
if_req  in  1  line-fill request, held until if_last
if_addr  in  ADDR_W  line base address, aligned to LINE_WORDS*4
if_valid  out  1  one-cycle pulse: if_data holds word if_idx
if_idx  out  4  word index within the line
if_data  out  32  returned word
if_last  out  1  with if_valid on the final word
lsb_req  in  1  access request, held until lsb_done
lsb_is_write  in  1  1 = store
lsb_addr  in  ADDR_W  access address
lsb_wdata  in  32  store data
lsb_type  in  3  bit2 = unsigned, [1:0] 00 byte / 01 half / 10 word
lsb_done  out  1  one-cycle pulse on completion (loads and stores)
lsb_rdata  out  32  load data, valid with lsb_done
mem_new_task  out  1  task strobe to the controller
mem_is_write  out  1  task direction
mem_addr  out  ADDR_W  task address
mem_data_in  out  32  task store data
mem_work_type  out  3  task type, same encoding as lsb_type
mem_data_out  in  32  controller read data
mem_ready  in  1  controller read-data-ready
mem_is_working  in  1  controller busy

Behaviour:
- Reset (async, rst_n_in=0): state IDLE, word counter 0, rr_pri=IF. All outputs 0.
- All outputs are registered. When rdy_in=0, no register changes, so an asserted mem_new_task stays asserted until a rdy cycle.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, no rob_clear: pick a requester.
  - If only one is pending, it wins. If both are pending, the one named by rr_pri wins, and rr_pri flips to the other client when the winner's transaction ends.
  - LSB read requests are ignored while rob_clear=1. LSB writes and if_req are never issued in a rob_clear cycle.
  - On a grant, register the mem_* fields and go to ISSUE with mem_new_task=1.
  - Ifetch task fields: mem_addr = if_addr + 4*counter, type 3'b010, read.
- ISSUE lasts exactly 1 accepted cycle. mem_new_task drops and the state goes to WAIT.
- rob_clear during ISSUE:
  - Read task: drop new_task, return to IDLE, clear the counter, no response.
  - Write task: stay in ISSUE with new_task held, because the controller ignores new_task during a flush; retry on the next cycle.
- WAIT: done on the first cycle with mem_is_working=0.
  - Load done: lsb_rdata <= mem_data_out, lsb_done=1.
  - Store done: lsb_done=1.
  - Ifetch done: if_valid=1, if_data <= mem_data_out, if_idx=counter, counter++.
  - If counter was LINE_WORDS-1: set if_last, clear the counter, go to IDLE. Otherwise go directly back to ISSUE for the next word; a line fill is not preempted.
- rob_clear during WAIT:
  - Read task: go to IDLE, clear the counter, suppress if_valid/lsb_done.
  - Write task: unaffected.
- Latency, request to response, assuming rdy_in=1:
  - Byte access: 3 cycles.
  - Word access: 6 cycles.
  - Full line: LINE_WORDS*5+1 cycles.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
MEM_ARB_IO_STALL_EN
- Defined: adds input io_buffer_full (1 bit). An LSB store with lsb_addr[17:16]==2'b11 is not granted while io_buffer_full=1. Ifetch may be granted meanwhile.
- Undefined: the port is absent and I/O stores are granted like any other store.

Test Plan:
- Single word load, lsb_addr=0x100, controller model returns 0xDEADBEEF → mem_new_task one cycle with type 3'b010; lsb_done 6 cycles after lsb_req; lsb_rdata=0xDEADBEEF.
- Line fill, if_addr=0x40, LINE_WORDS=4 → mem_addr sequence 0x40/44/48/4C; four if_valid pulses with if_idx 0..3; if_last only on idx 3.
- if_req and lsb_req (byte store) asserted together from reset → ifetch line first, then the store; second round with both pending → store first.
- rob_clear during WAIT of word 2 of a line fill → no further if_valid; IDLE next cycle; counter restarts at 0 on the next if_req.
- rob_clear in the ISSUE cycle of a store of 0x12 → mem_new_task held until the cycle after rob_clear; lsb_done still pulses once.
- rdy_in low for 3 cycles during ISSUE → mem_new_task stays high; completion is delayed by exactly 3 cycles.
- With MEM_ARB_IO_STALL_EN defined: io_buffer_full=1 and a store to 0x30000 → no grant until io_buffer_full=0, then lsb_done follows.
